routed_vector_fifo: RTL and testbench
=====================================

# routed_vector_fifo

Buffers the 20-lane × 8-bit routed vectors produced by the vector-core routing crossbar stage and hands them to the downstream MAC/PE array over a valid/ready handshake. The crossbar stage has no backpressure input, so this block also tells the upstream controller when to stop issuing. It tags each vector with a per-lane zero mask for the sparse datapath. It marks group boundaries (`out_last`) so the MAC array knows when a psum accumulation group ends.

## Interface
Parameters:
- `LANES`, 20, byte lanes per vector
- `DW`, 8, bits per lane
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `AFULL_SLACK`, 2, free-entry margin covering upstream issue-to-arrival latency

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `in_data`  in  LANES*DW  routed vector from crossbar output register, lane i at `[DW*i +: DW]`
- `in_vld`  in  1  `in_data` valid this cycle; no ready returned
- `afull`  out  1  `count >= DEPTH-AFULL_SLACK`; upstream must deassert issue while high
- `out_data`  out  LANES*DW  head entry data
- `out_zmask`  out  LANES  bit i = 1 when head lane i == 0
- `out_vld`  out  1  FIFO non-empty
- `out_rdy`  in  1  consumer accepts head this cycle
- `out_last`  out  1  head is final beat of current group
- `grp_start`  in  1  latch `grp_len`, clear beat counter
- `grp_len`  in  8  beats per group, 0 means 256
- `grp_done`  out  1  one-cycle pulse, cycle after last beat popped
- `flush`  in  1  synchronous clear of FIFO contents and beat counter
- `ovf`  out  1  sticky: a write was dropped
- `ovf_clr`  in  1  clears `ovf`
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of `{zmask, data}`; zmask computed from `in_data` at write time, stored with it.
- `wr_ptr` and `rd_ptr` wrap modulo DEPTH. `count` is a separate register.
- push = `in_vld & (count<DEPTH | pop)`; pop = `out_vld & out_rdy`.
- Simultaneous push+pop: count unchanged. Full+pop+push accepted. Empty+push: no pop possible the same cycle.
- `in_vld` while full without pop: data dropped, `ovf` set next cycle, pointers untouched.
- `out_data`/`out_zmask` = entry at `rd_ptr`, first-word fall-through from registers. When empty they are don't-care and `out_vld`=0.
- Group logic: `len_r` (9 bits, 0→256) loaded on `grp_start`; `beat` (8 bits) cleared on `grp_start`. `out_last = out_vld & (beat == len_r-1)`.
  - Pop with `out_last`: `beat`←0, `grp_done`=1 next cycle. Other pops: `beat`+1.
  - `grp_start` and pop in the same cycle: `grp_start` wins; the popped beat is counted as beat 0 of the new group, so `beat`←1, or a `grp_done` pulse if the new length is 1.
- `flush`: `count`, pointers and `beat` ←0 next cycle. `len_r` and `ovf` are kept. Overrides push and pop in the same cycle (the popped word is considered consumed; a concurrent push is discarded without setting `ovf`).
- `ovf_clr` and a drop in the same cycle: `ovf` stays 1 (set wins).

## Timing
- Reset values: `out_vld`=0, `count`=0, `afull`=0 (for AFULL_SLACK<DEPTH), `out_last`=0, `grp_done`=0, `ovf`=0, pointers 0, `beat`=0, `len_r`=256. `out_data` is unspecified.
- Latency: push at edge N → `out_vld`=1 and data at head from cycle N+1. Zero-bubble throughput: one push and one pop per cycle sustained.
- `afull` is a function of registered `count`, so it is visible the cycle after the push that crosses the threshold. With the one-cycle crossbar register plus a one-cycle controller reaction, AFULL_SLACK=2 guarantees no drop.
- `grp_done` is registered, exactly one cycle wide.
- Async reset mid-transfer discards all contents immediately. No output glitches to 1 during reset.

## Test plan
- Reset, then push V0..V3 (lane i of Vk = 4k+i+1) with `out_rdy`=0 → `count`=4, `afull`=1 from count 2, `out_data`=V0. Then `out_rdy`=1 → V0..V3 emerge in 4 consecutive cycles, `out_vld` falls after V3.
- Full FIFO, push V4 with `out_rdy`=0 → V4 dropped, `ovf`=1, `count`=4. Repeat with `out_rdy`=1 the same cycle → V4 accepted, `ovf` unchanged.
- Push a vector with lanes 0,5,19 = 0x00 and others 0x7F → `out_zmask`=0x80021.
- `grp_start` with `grp_len`=3, stream 7 vectors with `out_rdy` toggling 1,0,1 → `out_last` on beats 3 and 6, `grp_done` pulses cycle after each; 7th vector is beat 1 of next group.
- `grp_len`=0 (256 beats), stream 256 vectors → single `out_last` on the 256th, `beat` wraps to 0.
- Two entries queued, assert `flush` together with `in_vld` and a pop → next cycle `count`=0, `out_vld`=0, `ovf`=0. Then async reset during a streaming burst → all outputs at reset values within the reset cycle.

Source files
------------

// File: rtl/routed_vector_fifo.sv
// routed_vector_fifo: buffers routed crossbar vectors with per-lane zero masks, tags group
// boundaries for the MAC array and reports almost-full / overflow back to the issuer.
module routed_vector_fifo #(
    parameter int unsigned LANES       = 20,
    parameter int unsigned DW          = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_SLACK = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [LANES*DW-1:0]      in_data,
    input  logic                     in_vld,
    output logic                     afull,
    output logic [LANES*DW-1:0]      out_data,
    output logic [LANES-1:0]         out_zmask,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_last,
    input  logic                     grp_start,
    input  logic [7:0]               grp_len,
    output logic                     grp_done,
    input  logic                     flush,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - AFULL_SLACK);

    logic [LANES*DW-1:0] r_mem_data [DEPTH];
    logic [LANES-1:0]    r_mem_zm   [DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_count;
    logic [8:0]          r_len;
    logic [7:0]          r_beat;
    logic                r_grp_done;
    logic                r_ovf;

    logic                w_pop, w_push, w_drop;
    logic [8:0]          w_new_len;
    logic [LANES-1:0]    w_zmask;

    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            w_zmask[i] = (in_data[DW*i +: DW] == '0);
        end
    end

    always_comb begin
        out_vld   = (r_count != '0);
        out_last  = out_vld & ({1'b0, r_beat} == (r_len - 9'd1));
        afull     = (r_count >= AFULL_CNT);
        count     = r_count;
        ovf       = r_ovf;
        grp_done  = r_grp_done;
        out_data  = r_mem_data[r_rd_ptr];
        out_zmask = r_mem_zm[r_rd_ptr];
        w_pop     = out_vld & out_rdy;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        w_push    = in_vld & ((r_count != FULL_CNT) | w_pop);
        w_drop    = in_vld & ~w_push & ~flush;
        w_new_len = (grp_len == 8'd0) ? 9'd256 : {1'b0, grp_len};
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_zm[r_wr_ptr]   <= w_zmask;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len      <= 9'd256;
            r_beat     <= '0;
            r_grp_done <= 1'b0;
        end else begin
            r_grp_done <= 1'b0;
            if (grp_start) r_len <= w_new_len;
            if (flush) begin
                r_beat <= '0;
            end else if (grp_start) begin
                // A beat popped alongside grp_start is beat 0 of the new group.
                if (w_pop && (w_new_len == 9'd1)) begin
                    r_beat     <= '0;
                    r_grp_done <= 1'b1;
                end else begin
                    r_beat <= w_pop ? 8'd1 : 8'd0;
                end
            end else if (w_pop) begin
                if (out_last) begin
                    r_beat     <= '0;
                    r_grp_done <= 1'b1;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_routed_vector_fifo.sv
// Self-checking bench for routed_vector_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_routed_vector_fifo;
    localparam int LANES = 20;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SLACK = 2;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          in_vld = 1'b0;
    logic          afull;
    logic [VW-1:0] out_data;
    logic [LANES-1:0] out_zmask;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic          out_last;
    logic          grp_start = 1'b0;
    logic [7:0]    grp_len = 8'd0;
    logic          grp_done;
    logic          flush = 1'b0;
    logic          ovf;
    logic          ovf_clr = 1'b0;
    logic [2:0]    count;
    logic [7:0]    dut_status;

    int n_cmp = 0;
    int n_fail = 0;

    logic [VW-1:0] m_q[$];
    int m_len  = 256;
    int m_beat = 0;
    bit m_ovf  = 1'b0;
    bit m_done = 1'b0;

    routed_vector_fifo #(
        .LANES(LANES), .DW(DW), .DEPTH(DEPTH), .AFULL_SLACK(SLACK)
    ) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_vld(in_vld), .afull(afull),
        .out_data(out_data), .out_zmask(out_zmask), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_last(out_last), .grp_start(grp_start), .grp_len(grp_len), .grp_done(grp_done),
        .flush(flush), .ovf(ovf), .ovf_clr(ovf_clr), .count(count)
    );

    always #5 clk = ~clk;

    assign dut_status = {out_vld, out_last, grp_done, ovf, afull, count};

    function automatic logic [VW-1:0] mkvec(int k);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[DW*i +: DW] = DW'(4 * k + i + 1);
        return v;
    endfunction

    function automatic logic [LANES-1:0] zm_of(logic [VW-1:0] v);
        logic [LANES-1:0] z;
        for (int i = 0; i < LANES; i++) z[i] = (v[DW*i +: DW] == 8'h00);
        return z;
    endfunction

    // {out_vld, out_last, grp_done, ovf, afull, count} predicted from the model
    function automatic logic [7:0] exp_status();
        int sz;
        sz = m_q.size();
        return {sz > 0, (sz > 0) && (m_beat == m_len - 1), m_done, m_ovf,
                sz >= DEPTH - SLACK, 3'(sz)};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_len  = 256;
        m_beat = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endfunction

    // Advance the model by one clock with the current inputs, then move to 1ns after the edge.
    task automatic tick();
        int sz;
        int nl;
        bit pop;
        bit acc;
        bit drop;
        sz   = m_q.size();
        pop  = (sz > 0) && out_rdy;
        acc  = in_vld && ((sz < DEPTH) || pop);
        drop = in_vld && !acc && !flush;
        nl   = (grp_len == 8'd0) ? 256 : int'(grp_len);
        m_done = 1'b0;
        if (flush) begin
            m_q.delete();
            m_beat = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(in_data);
            if (grp_start) begin
                m_beat = pop ? (1 % nl) : 0;
                m_done = pop && (nl == 1);
            end else if (pop) begin
                m_beat = (m_beat + 1) % m_len;
                m_done = (m_beat == 0);
            end
        end
        if (grp_start) m_len = nl;
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (dut_status !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_during: status got %b want %b", dut_status, 8'h00);
        end
        #4 rstn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dut_status !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_after: status got %b want %b", dut_status, 8'h00);
        end
    endtask

    task automatic test_fill_drain();
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1;
            in_data = mkvec(k);
            tick();
            n_cmp++;
            if (count !== 3'(k + 1) || afull !== (k >= 1) || out_data !== mkvec(0)) begin
                n_fail++;
                $display("FAIL fill_%0d: count=%0d afull=%b head=%h want count=%0d afull=%b head=%h",
                         k, count, afull, out_data, k + 1, k >= 1, mkvec(0));
            end
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_vld !== 1'b1 || out_data !== mkvec(k)) begin
                n_fail++;
                $display("FAIL drain_%0d: vld=%b data=%h want vld=1 data=%h",
                         k, out_vld, out_data, mkvec(k));
            end
            tick();
        end
        n_cmp++;
        if (out_vld !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: vld=%b count=%0d want vld=0 count=0", out_vld, count);
        end
    endtask

    task automatic test_overflow();
        out_rdy = 1'b0;
        in_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = mkvec(k);
            tick();
        end
        in_data = mkvec(4);
        tick();
        n_cmp++;
        if (ovf !== 1'b1 || count !== 3'd4 || out_data !== mkvec(0)) begin
            n_fail++;
            $display("FAIL ovf_drop: ovf=%b count=%0d head=%h want ovf=1 count=4 head=%h",
                     ovf, count, out_data, mkvec(0));
        end
        out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1 || count !== 3'd4 || out_data !== mkvec(1)) begin
            n_fail++;
            $display("FAIL ovf_full_pop_push: ovf=%b count=%0d head=%h want ovf=1 count=4 head=%h",
                     ovf, count, out_data, mkvec(1));
        end
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (out_vld !== 1'b1 || out_data !== mkvec(k)) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: vld=%b data=%h want %h", k, out_vld, out_data,
                         mkvec(k));
            end
            tick();
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf got %b want 0", ovf);
        end
    endtask

    task automatic test_zmask();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[DW*i +: DW] = 8'h7F;
        v[DW*0 +: DW] = 8'h00;
        v[DW*5 +: DW] = 8'h00;
        v[DW*19 +: DW] = 8'h00;
        out_rdy = 1'b0;
        in_vld = 1'b1;
        in_data = v;
        tick();
        in_vld = 1'b0;
        n_cmp++;
        if (out_zmask !== 20'h80021 || out_data !== v) begin
            n_fail++;
            $display("FAIL zmask: zmask=%h data=%h want zmask=80021 data=%h", out_zmask, out_data, v);
        end
        out_rdy = 1'b1;
        tick();
        n_cmp++;
        if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL zmask_pop: vld got %b want 0", out_vld);
        end
    endtask

    task automatic test_groups();
        int pushed = 0;
        int pops = 0;
        int lasts = 0;
        int dones = 0;
        logic [6:0] last_mask = '0;
        out_rdy = 1'b0;
        grp_start = 1'b1;
        grp_len = 8'd3;
        tick();
        grp_start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_vld = (pushed < 7) && (m_q.size() < DEPTH - SLACK);
            in_data = mkvec(10 + pushed);
            out_rdy = (cyc % 2 == 0);
            n_cmp++;
            if (dut_status !== exp_status()) begin
                n_fail++;
                $display("FAIL grp_status@%0d: got %b want %b", cyc, dut_status, exp_status());
            end
            if (grp_done === 1'b1) dones++;
            if (out_vld === 1'b1 && out_rdy) begin
                if (out_last === 1'b1) begin
                    lasts++;
                    if (pops < 7) last_mask[pops] = 1'b1;
                end
                pops++;
            end
            tick();
            if (in_vld) pushed++;
        end
        in_vld = 1'b0;
        n_cmp++;
        if (lasts !== 2 || last_mask !== 7'b0100100 || dones !== 2 || pops !== 7) begin
            n_fail++;
            $display("FAIL grp_len3: lasts=%0d mask=%b dones=%0d pops=%0d want 2 0100100 2 7",
                     lasts, last_mask, dones, pops);
        end
        n_cmp++;
        if (m_beat != 1) begin
            n_fail++;
            $display("FAIL grp_carry: model beat got %0d want 1", m_beat);
        end
    endtask

    task automatic test_long_group();
        int pushed = 0;
        int pops = 0;
        int lasts = 0;
        int last_at = 0;
        out_rdy = 1'b0;
        grp_start = 1'b1;
        grp_len = 8'd0;
        tick();
        grp_start = 1'b0;
        out_rdy = 1'b1;
        for (int cyc = 0; cyc < 300 && pops < 256; cyc++) begin
            in_vld = (pushed < 256);
            in_data = mkvec(pushed % 50);
            n_cmp++;
            if (dut_status !== exp_status()) begin
                n_fail++;
                $display("FAIL long_status@%0d: got %b want %b", cyc, dut_status, exp_status());
            end
            if (out_vld === 1'b1) begin
                pops++;
                if (out_last === 1'b1) begin
                    lasts++;
                    last_at = pops;
                end
            end
            tick();
            if (in_vld) pushed++;
        end
        in_vld = 1'b0;
        n_cmp++;
        if (lasts !== 1 || last_at !== 256 || pops !== 256) begin
            n_fail++;
            $display("FAIL long_group: lasts=%0d at=%0d pops=%0d want 1 256 256", lasts, last_at, pops);
        end
        out_rdy = 1'b0;
        in_vld = 1'b1;
        in_data = mkvec(3);
        tick();
        in_vld = 1'b0;
        n_cmp++;
        if (out_vld !== 1'b1 || out_last !== 1'b0 || grp_done !== 1'b0) begin
            n_fail++;
            $display("FAIL long_wrap: vld=%b last=%b done=%b want 1 0 0", out_vld, out_last, grp_done);
        end
        out_rdy = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < LANES; i++)
                in_data[DW*i +: DW] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            in_vld = ($urandom_range(0, 3) != 0) &&
                     ((m_q.size() < DEPTH - SLACK) || ($urandom_range(0, 5) == 0));
            out_rdy = ($urandom_range(0, 9) < 7);
            grp_start = ($urandom_range(0, 39) == 0);
            grp_len = 8'($urandom_range(0, 4));
            flush = ($urandom_range(0, 59) == 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            n_cmp++;
            if (dut_status !== exp_status()) begin
                n_fail++;
                $display("FAIL rand_status@%0d: got %b want %b", cyc, dut_status, exp_status());
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if ({out_zmask, out_data} !== {zm_of(m_q[0]), m_q[0]}) begin
                    n_fail++;
                    $display("FAIL rand_head@%0d: got %h/%h want %h/%h", cyc, out_zmask, out_data,
                             zm_of(m_q[0]), m_q[0]);
                end
            end
            tick();
        end
        in_vld = 1'b0;
        grp_start = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) tick();
    endtask

    task automatic test_flush();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        out_rdy = 1'b0;
        in_vld = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = mkvec(20 + k);
            tick();
        end
        in_data = mkvec(30);
        flush = 1'b1;
        out_rdy = 1'b1;
        tick();
        flush = 1'b0;
        in_vld = 1'b0;
        n_cmp++;
        if (count !== 3'd0 || out_vld !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: count=%0d vld=%b ovf=%b want 0 0 0", count, out_vld, ovf);
        end
        n_cmp++;
        if (dut_status !== exp_status()) begin
            n_fail++;
            $display("FAIL flush_status: got %b want %b", dut_status, exp_status());
        end
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b1;
        in_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = mkvec(k);
            tick();
        end
        out_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_data = mkvec(k + 5);
            tick();
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (dut_status !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: status got %b want %b", dut_status, 8'h00);
        end
        in_vld = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b1;
        in_data = mkvec(9);
        tick();
        in_vld = 1'b0;
        n_cmp++;
        if (dut_status !== exp_status() || out_data !== mkvec(9)) begin
            n_fail++;
            $display("FAIL post_reset: status=%b data=%h want %b %h", dut_status, out_data,
                     exp_status(), mkvec(9));
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_zmask();
        test_groups();
        test_long_group();
        test_random();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
